// File: rtl/aurora_link_supervisor.sv
// Link bring-up and health supervisor for an N-lane Aurora 64B66B channel.
// Sequences reset_pb/pma_init, retries bring-up on timeout and re-inits a link that goes bad.
module aurora_link_supervisor #(
   parameter int NUM_LANES   = 2,
   parameter int CNT_W       = 24,
   parameter int RST_PB_LEAD = 128,
   parameter int PMA_HOLD    = 1024,
   parameter int RST_PB_LAG  = 128,
   parameter int UP_TIMEOUT  = 1000000,
   parameter int DROP_FILTER = 16,
   parameter int SOFT_THRESH = 8,
   parameter int SOFT_WIN    = 65536,
   parameter int MAX_RETRY   = 4
) (
   input  logic                 init_clk,
   input  logic                 system_rst_n,
   input  logic                 channel_up,
   input  logic [NUM_LANES-1:0] lane_up,
   input  logic                 hard_err,
   input  logic                 soft_err,
   input  logic                 force_reinit,
   output logic                 reset_pb,
   output logic                 pma_init,
   output logic                 link_ok,
   output logic                 link_fail,
   output logic [2:0]           state,
   output logic [7:0]           retry_cnt,
   output logic [15:0]          reinit_cnt,
   output logic [2:0]           last_cause
);

   typedef enum logic [2:0] {
      ST_RST_LEAD = 3'd0,
      ST_PMA_ON   = 3'd1,
      ST_PMA_OFF  = 3'd2,
      ST_WAIT_UP  = 3'd3,
      ST_LINK_UP  = 3'd4,
      ST_FAIL     = 3'd5
   } state_t;

   localparam logic [2:0] CAUSE_FORCE   = 3'd1;
   localparam logic [2:0] CAUSE_HARD    = 3'd2;
   localparam logic [2:0] CAUSE_DROP    = 3'd3;
   localparam logic [2:0] CAUSE_SOFT    = 3'd4;
   localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

   localparam logic [CNT_W-1:0] LEAD_LAST    = CNT_W'(RST_PB_LEAD - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PMA_HOLD - 1);
   localparam logic [CNT_W-1:0] LAG_LAST     = CNT_W'(RST_PB_LAG - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(UP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WIN_LAST     = CNT_W'(SOFT_WIN - 1);
   localparam logic [CNT_W-1:0] DROP_LIMIT   = CNT_W'(DROP_FILTER);
   localparam logic [CNT_W-1:0] SOFT_LIMIT   = CNT_W'(SOFT_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   // A limit above 255 can never be reached by the saturating retry counter.
   localparam bit         RETRY_BOUNDED = (MAX_RETRY > 0) && (MAX_RETRY < 256);
   localparam logic [7:0] RETRY_LIMIT   = 8'(MAX_RETRY);

   logic [1:0]           ch_sync;
   logic [1:0]           hard_sync;
   logic [2:0]           soft_sync;
   logic [NUM_LANES-1:0] lane_s1;
   logic [NUM_LANES-1:0] lane_s2;

   always_ff @(posedge init_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         ch_sync   <= '0;
         hard_sync <= '0;
         soft_sync <= '0;
         lane_s1   <= '0;
         lane_s2   <= '0;
      end else begin
         ch_sync   <= {ch_sync[0], channel_up};
         hard_sync <= {hard_sync[0], hard_err};
         soft_sync <= {soft_sync[1:0], soft_err};
         lane_s1   <= lane_up;
         lane_s2   <= lane_s1;
      end
   end

   logic up;
   logic hard;
   logic soft_rise;

   assign up        = ch_sync[1] & (&lane_s2);
   assign hard      = hard_sync[1];
   assign soft_rise = soft_sync[1] & ~soft_sync[2];

   state_t           st_q, st_d;
   logic [CNT_W-1:0] phase_cnt, phase_d;
   logic [CNT_W-1:0] drop_cnt, drop_d;
   logic [CNT_W-1:0] win_cnt, win_d;
   logic [CNT_W-1:0] soft_cnt, soft_d;
   logic [7:0]       retry_q, retry_d, retry_inc;
   logic [15:0]      reinit_q, reinit_d, reinit_inc;
   logic [2:0]       cause_q, cause_d;
   logic             restart;
   logic             trig;

   assign retry_inc  = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
   assign reinit_inc = (reinit_q == 16'hFFFF) ? reinit_q : reinit_q + 16'd1;

   always_comb begin
      st_d     = st_q;
      phase_d  = phase_cnt + CNT_ONE;
      drop_d   = '0;
      win_d    = '0;
      soft_d   = '0;
      retry_d  = retry_q;
      reinit_d = reinit_q;
      cause_d  = cause_q;
      restart  = 1'b0;
      trig     = 1'b0;

      case (st_q)
         ST_RST_LEAD, ST_PMA_ON, ST_PMA_OFF: begin
            if (force_reinit) begin
               st_d    = ST_RST_LEAD;
               cause_d = CAUSE_FORCE;
               restart = 1'b1;
            end else if (st_q == ST_RST_LEAD && phase_cnt == LEAD_LAST) begin
               st_d = ST_PMA_ON;
            end else if (st_q == ST_PMA_ON && phase_cnt == HOLD_LAST) begin
               st_d = ST_PMA_OFF;
            end else if (st_q == ST_PMA_OFF && phase_cnt == LAG_LAST) begin
               st_d = ST_WAIT_UP;
            end
         end

         ST_WAIT_UP: begin
            // A link that comes up on the timeout cycle is taken, not retried.
            if (force_reinit) begin
               st_d    = ST_RST_LEAD;
               cause_d = CAUSE_FORCE;
            end else if (up) begin
               st_d    = ST_LINK_UP;
               retry_d = 8'd0;
            end else if (phase_cnt == TIMEOUT_LAST) begin
               cause_d = CAUSE_TIMEOUT;
               retry_d = retry_inc;
               st_d    = (RETRY_BOUNDED && retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RST_LEAD;
            end
         end

         ST_LINK_UP: begin
            drop_d = up ? '0 : drop_cnt + CNT_ONE;
            win_d  = (win_cnt == WIN_LAST) ? '0 : win_cnt + CNT_ONE;
            // An edge landing on the window wrap is counted in the new window.
            soft_d = ((win_cnt == WIN_LAST) ? '0 : soft_cnt) + (soft_rise ? CNT_ONE : '0);
            trig   = 1'b1;
            if (force_reinit) begin
               cause_d = CAUSE_FORCE;
            end else if (hard) begin
               cause_d = CAUSE_HARD;
            end else if (drop_d == DROP_LIMIT) begin
               cause_d = CAUSE_DROP;
            end else if (soft_d >= SOFT_LIMIT) begin
               cause_d = CAUSE_SOFT;
            end else begin
               trig = 1'b0;
            end
            if (trig) begin
               st_d     = ST_RST_LEAD;
               reinit_d = reinit_inc;
            end
         end

         ST_FAIL: begin
            if (force_reinit) begin
               st_d    = ST_RST_LEAD;
               retry_d = 8'd0;
               cause_d = CAUSE_FORCE;
            end
         end

         default: begin
            st_d = ST_RST_LEAD;
         end
      endcase

      if (restart || st_d != st_q || st_q == ST_LINK_UP || st_q == ST_FAIL) begin
         phase_d = '0;
      end
   end

   always_ff @(posedge init_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         st_q       <= ST_RST_LEAD;
         phase_cnt  <= '0;
         drop_cnt   <= '0;
         win_cnt    <= '0;
         soft_cnt   <= '0;
         retry_q    <= 8'd0;
         reinit_q   <= 16'd0;
         cause_q    <= 3'd0;
         reset_pb   <= 1'b1;
         pma_init   <= 1'b0;
         link_ok    <= 1'b0;
         link_fail  <= 1'b0;
      end else begin
         st_q       <= st_d;
         phase_cnt  <= phase_d;
         drop_cnt   <= drop_d;
         win_cnt    <= win_d;
         soft_cnt   <= soft_d;
         retry_q    <= retry_d;
         reinit_q   <= reinit_d;
         cause_q    <= cause_d;
         // FAIL parks the core with both resets asserted.
         reset_pb   <= (st_d != ST_WAIT_UP) && (st_d != ST_LINK_UP);
         pma_init   <= (st_d == ST_PMA_ON) || (st_d == ST_FAIL);
         link_ok    <= (st_d == ST_LINK_UP);
         link_fail  <= (st_d == ST_FAIL);
      end
   end

   assign state      = st_q;
   assign retry_cnt  = retry_q;
   assign reinit_cnt = reinit_q;
   assign last_cause = cause_q;

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Bench for aurora_link_supervisor: a cycle model of the supervisor rules checked
// against the DUT every cycle, plus directed scenarios with hand-computed values.
module tb_aurora_link_supervisor;

   localparam int NL    = 2;
   localparam int CW    = 24;
   localparam int LEAD  = 4;
   localparam int HOLD  = 8;
   localparam int LAG   = 4;
   localparam int TMO   = 50;
   localparam int DROPF = 3;
   localparam int STH   = 4;
   localparam int SWIN  = 100;
   localparam int MAXR  = 2;

   localparam int S_LEAD = 0;
   localparam int S_PON  = 1;
   localparam int S_POFF = 2;
   localparam int S_WAIT = 3;
   localparam int S_LINK = 4;
   localparam int S_FAIL = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          channel_up;
   logic [NL-1:0] lane_up;
   logic          hard_err;
   logic          soft_err;
   logic          force_reinit;
   logic          reset_pb;
   logic          pma_init;
   logic          link_ok;
   logic          link_fail;
   logic [2:0]    state;
   logic [7:0]    retry_cnt;
   logic [15:0]   reinit_cnt;
   logic [2:0]    last_cause;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aurora_link_supervisor #(
      .NUM_LANES(NL), .CNT_W(CW), .RST_PB_LEAD(LEAD), .PMA_HOLD(HOLD),
      .RST_PB_LAG(LAG), .UP_TIMEOUT(TMO), .DROP_FILTER(DROPF),
      .SOFT_THRESH(STH), .SOFT_WIN(SWIN), .MAX_RETRY(MAXR)
   ) dut (
      .init_clk(clk),
      .system_rst_n(rst_n),
      .channel_up(channel_up),
      .lane_up(lane_up),
      .hard_err(hard_err),
      .soft_err(soft_err),
      .force_reinit(force_reinit),
      .reset_pb(reset_pb),
      .pma_init(pma_init),
      .link_ok(link_ok),
      .link_fail(link_fail),
      .state(state),
      .retry_cnt(retry_cnt),
      .reinit_cnt(reinit_cnt),
      .last_cause(last_cause)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_state, m_t, m_retry, m_reinit, m_cause;
   int       m_drop, m_win, m_soft, m_nxt, m_new_cause, win_idx;
   bit       m_reenter;
   logic [2:0] up_h, hard_h;
   logic [3:0] soft_h;
   logic       upv, hardv, rise;

   function automatic int phase_len(input int s);
      case (s)
         S_LEAD:  return LEAD;
         S_PON:   return HOLD;
         S_POFF:  return LAG;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state = S_LEAD; m_t = 0; m_retry = 0; m_reinit = 0; m_cause = 0;
      m_drop = 0; m_win = 0; m_soft = 0;
      up_h = '0; hard_h = '0; soft_h = '0;
   endtask

   task automatic model_step();
      // Inputs reach the decision logic two cycles after they are driven.
      up_h   = {up_h[1:0], channel_up & (&lane_up)};
      hard_h = {hard_h[1:0], hard_err};
      soft_h = {soft_h[2:0], soft_err};
      upv    = up_h[2];
      hardv  = hard_h[2];
      rise   = soft_h[2] & ~soft_h[3];
      m_nxt = m_state;
      m_reenter = 1'b0;
      if (m_state == S_LINK) begin
         win_idx = (m_t + 1) / SWIN;
         if (win_idx != m_win) begin
            m_win = win_idx;
            m_soft = 0;
         end
         if (rise) m_soft++;
         m_drop = upv ? 0 : m_drop + 1;
         m_new_cause = force_reinit ? 1 : hardv ? 2 : (m_drop >= DROPF) ? 3 :
                       (m_soft >= STH) ? 4 : 0;
         if (m_new_cause != 0) begin
            m_cause = m_new_cause;
            if (m_reinit < 65535) m_reinit++;
            m_nxt = S_LEAD;
         end
      end else if (m_state == S_FAIL) begin
         if (force_reinit) begin
            m_nxt = S_LEAD; m_retry = 0; m_cause = 1;
         end
      end else if (force_reinit) begin
         m_nxt = S_LEAD; m_reenter = 1'b1; m_cause = 1;
      end else if (m_state == S_WAIT) begin
         if (upv) begin
            m_nxt = S_LINK; m_retry = 0;
         end else if (m_t + 1 == TMO) begin
            if (m_retry < 255) m_retry++;
            m_cause = 5;
            m_nxt = (MAXR != 0 && m_retry == MAXR) ? S_FAIL : S_LEAD;
         end
      end else if (m_t + 1 == phase_len(m_state)) begin
         m_nxt = m_state + 1;
      end
      if (m_nxt != m_state || m_reenter) begin
         m_t = 0;
         if (m_nxt == S_LINK) begin
            m_drop = 0; m_win = 0; m_soft = 0;
         end
      end else begin
         m_t++;
      end
      m_state = m_nxt;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("cmp_state", state, m_state);
         check("cmp_retry_cnt", retry_cnt, m_retry);
         check("cmp_reinit_cnt", reinit_cnt, m_reinit);
         check("cmp_last_cause", last_cause, m_cause);
         check("cmp_reset_pb", reset_pb, (m_state != S_WAIT) && (m_state != S_LINK));
         check("cmp_pma_init", pma_init, (m_state == S_PON) || (m_state == S_FAIL));
         check("cmp_link_ok", link_ok, m_state == S_LINK);
         check("cmp_link_fail", link_fail, m_state == S_FAIL);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_link(input string name);
      int n;
      n = 0;
      while (link_ok !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, link_ok, 1);
   endtask

   task automatic soft_pulse();
      soft_err = 1'b1;
      tick(4);
      soft_err = 1'b0;
      tick(8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      channel_up = 1'b0; lane_up = '0; hard_err = 1'b0; soft_err = 1'b0; force_reinit = 1'b0;
      #2 rst_n = 1'b0;
      tick(2);
      check("rst_reset_pb", reset_pb, 1);
      check("rst_pma_init", pma_init, 0);
      check("rst_state", state, 0);
      check("rst_counters", {retry_cnt, reinit_cnt, last_cause}, 0);
      check("rst_flags", {link_ok, link_fail}, 0);

      // Bring-up: release at cycle 0, link inputs up from cycle 10.
      rst_n = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (c == 10) begin
            channel_up = 1'b1;
            lane_up = '1;
         end
         @(negedge clk);
         check("t1_reset_pb", reset_pb, c < 16);
         check("t1_pma_init", pma_init, (c >= 4) && (c <= 11));
         if (c == 16) check("t1_wait_entry", state, 3);
         if (c == 17) check("t1_model_link", m_state, 4);
         if (c == 19) begin
            check("t1_link_ok", link_ok, 1);
            check("t1_retry", retry_cnt, 0);
         end
         @(posedge clk);
         #1;
      end

      // Drop filter: 2-cycle drop is filtered, 3-cycle drop re-inits.
      lane_up = 2'b01;
      tick(2);
      lane_up = 2'b11;
      tick(6);
      @(negedge clk);
      check("t3_short_drop_link_ok", link_ok, 1);
      @(posedge clk); #1;
      lane_up = 2'b01;
      tick(3);
      lane_up = 2'b11;
      tick(4);
      @(negedge clk);
      check("t3_drop_state", state, 0);
      check("t3_drop_cause", last_cause, 3);
      check("t3_drop_reinit", reinit_cnt, 1);
      wait_link("t3_relink");

      // Soft burst: 3 edges in the first window, 4 in the next.
      @(posedge clk); #1;
      repeat (3) soft_pulse();
      @(negedge clk);
      check("t4_win1_no_reinit", state, 4);
      @(posedge clk); #1;
      tick(69);
      repeat (3) soft_pulse();
      @(negedge clk);
      check("t4_win2_three_ok", link_ok, 1);
      @(posedge clk); #1;
      soft_err = 1'b1;
      tick(4);
      @(negedge clk);
      check("t4_burst_state", state, 0);
      check("t4_burst_cause", last_cause, 4);
      check("t4_burst_reinit", reinit_cnt, 2);
      soft_err = 1'b0;
      wait_link("t4_relink");

      // Priority: force and synchronised hard_err on the same cycle.
      @(posedge clk); #1;
      hard_err = 1'b1;
      tick(2);
      force_reinit = 1'b1;
      tick(1);
      force_reinit = 1'b0;
      hard_err = 1'b0;
      @(negedge clk);
      check("t5_prio_state", state, 0);
      check("t5_prio_cause", last_cause, 1);
      check("t5_prio_reinit", reinit_cnt, 3);
      wait_link("t5_relink");
      @(posedge clk); #1;
      hard_err = 1'b1;
      tick(4);
      hard_err = 1'b0;
      @(negedge clk);
      check("t5_hard_cause", last_cause, 2);
      check("t5_hard_reinit", reinit_cnt, 4);

      // Timeout and fail with channel_up held low.
      channel_up = 1'b0;
      lane_up = '0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      for (int c = 0; c < 133; c++) begin
         @(negedge clk);
         if (c == 65) check("t2_wait1_end", {state, retry_cnt}, {3'd3, 8'd0});
         if (c == 66) begin
            check("t2_retry1", retry_cnt, 1);
            check("t2_retry1_state", state, 0);
            check("t2_retry1_cause", last_cause, 5);
         end
         if (c == 131) check("t2_wait2_end", {state, retry_cnt}, {3'd3, 8'd1});
         if (c == 132) begin
            check("t2_fail_state", state, 5);
            check("t2_fail_flags", {link_fail, reset_pb, pma_init, link_ok}, 4'b1110);
            check("t2_fail_cause", last_cause, 5);
            check("t2_fail_retry", retry_cnt, 2);
            check("t2_model_fail", m_state, 5);
         end
         @(posedge clk);
         #1;
      end
      force_reinit = 1'b1;
      tick(1);
      force_reinit = 1'b0;
      @(negedge clk);
      check("t2_exit_state", state, 0);
      check("t2_exit_retry", retry_cnt, 0);
      @(posedge clk); #1;
      tick(89);
      @(negedge clk);
      check("t2_wait_again", {state, retry_cnt, last_cause}, {3'd3, 8'd1, 3'd5});
      @(posedge clk); #1;
      force_reinit = 1'b1;
      tick(1);
      force_reinit = 1'b0;
      @(negedge clk);
      check("t2_force_wait", {state, retry_cnt, last_cause}, {3'd0, 8'd1, 3'd1});

      // Reset in the middle of PMA_ON.
      @(posedge clk); #1;
      tick(4);
      @(negedge clk);
      check("t6_in_pma_on", {state, pma_init}, {3'd1, 1'b1});
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_reset_pb", reset_pb, 1);
      check("t6_pma_init", pma_init, 0);
      check("t6_state", state, 0);
      check("t6_counters", {retry_cnt, reinit_cnt, last_cause}, 0);
      check("t6_flags", {link_ok, link_fail}, 0);
      tick(3);
      rst_n = 1'b1;
      tick(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
